bit_op_seq: RTL
===============

# bit_op_seq

Sequencer for the CPU's bit-manipulation instructions (SBI, CBI, BST, BLD, BSET, BCLR, and optionally SBIC/SBIS). It sits between instruction decode and the combinational bit set/clear unit. It latches the instruction and the I/O read byte that feed that unit, then drives the register-file, SREG, T-flag and I/O-bus write strobes using the unit's result. SBI/CBI run as a two-phase read-modify-write on the I/O bus with wait-state support. While the sequence runs, the block stalls the front end.

## Interface
- IO_AW, 6, I/O bus address width; the 5-bit SBI/CBI A field is zero-extended to this width.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ir_valid  in  1  decode presents an instruction in ir
- ir  in  16  instruction word
- ir_ready  out  1  block can accept; high only in IDLE
- stall  out  1  front-end hold; equals !ir_ready
- ir_q  out  16  held instruction, drives the bit unit's ir input
- io_rdata_q  out  8  latched I/O read byte, drives the bit unit's io_rdata input
- bsc_ro  in  8  bit unit result
- bst_tf  in  1  bit unit BST transfer bit
- io_addr  out  IO_AW  I/O bus address
- io_re / io_we  out  1  I/O read / write strobes
- io_wdata  out  8  I/O write data
- io_rdata  in  8  I/O read data, valid in the cycle io_re is high and io_wait is low
- io_wait  in  1  peripheral wait state; extends the current I/O phase
- rf_we  out  1; rf_waddr  out  5; rf_wdata  out  8  register-file write port
- sreg_we  out  1; sreg_wdata  out  8  SREG write port
- tf_we  out  1; tf_wdata  out  1  T-flag write port
- skip_req  out  1  one-cycle skip-next-instruction request (BITOP_SKIP_EN only)

## Operation
- **States:** IDLE, IO_RD, IO_WR, WB, SKIP.
- **Accept:** an instruction is accepted when ir_valid && ir_ready. On accept, ir is captured into ir_q.
- **Accept transitions:**
  - SBI/CBI (and SBIC/SBIS when enabled) go to IO_RD.
  - BST, BLD, BSET and BCLR go to WB.
  - Any other opcode is ignored: the block stays in IDLE and drives no strobes.
- **IO_RD:** io_re=1, io_addr={0,ir_q[7:3]}.
  - If io_wait is high, the block stays in IO_RD.
  - Otherwise io_rdata is captured into io_rdata_q. The next state is IO_WR for SBI/CBI, or SKIP for SBIC/SBIS.
- **IO_WR:** io_we=1, same io_addr, io_wdata=bsc_ro.
  - If io_wait is high, the block stays in IO_WR; address and data must not change.
  - Otherwise the next state is IDLE.
- **WB:** exactly one strobe for one cycle, then IDLE.
  - BLD: rf_we=1, rf_waddr=ir_q[8:4], rf_wdata=bsc_ro.
  - BST: tf_we=1, tf_wdata=bst_tf.
  - BSET/BCLR: sreg_we=1, sreg_wdata=bsc_ro.
- **SKIP:** skip_req = (io_rdata_q[ir_q[2:0]] == ir_q[9]). Bit ir_q[9] is 1 for SBIS and 0 for SBIC. Next state is IDLE.
- **Strobe exclusivity:** all strobes are decoded from state and ir_q, and are 0 in any state not named above.
- **Reset values:**
  - State is IDLE; ir_q=0; io_rdata_q=0.
  - All strobes are 0 and skip_req=0.
  - ir_ready=1, stall=0.
- **Reset mid-operation:**
  - A reset in IO_RD or IO_WR aborts the operation with no I/O write issued after the reset edge.
  - A pending WB write is dropped.
  - rst takes priority over ir_valid in the same cycle.

## Timing
- All state, ir_q and io_rdata_q are registered on the rising clk edge. Outputs are combinational from the registered state.
- **SBI/CBI:** accept in cycle 0, io_re in cycle 1, io_we in cycle 2, ir_ready back high in cycle 3. Each io_wait cycle adds one cycle to the phase it occurs in.
- **BST/BLD/BSET/BCLR:** accept in cycle 0, strobe in cycle 1, ir_ready in cycle 2.
- **SBIC/SBIS:** accept in cycle 0, io_re in cycle 1, skip_req in cycle 2, ir_ready in cycle 3.
- **Back-to-back:** a new instruction can be accepted in the first cycle ir_ready is high again.
- **Ignored opcodes:** they never drop ir_ready.
- **Data setup:** bsc_ro and bst_tf must be valid in the strobe cycle. The bit unit is combinational, so they settle from ir_q, io_rdata_q and the register-file read within that cycle.

## Configuration
- **BITOP_SKIP_EN defined:**
  - SBIC (10011001AAAAAbbb) and SBIS (10011011AAAAAbbb) are accepted and run IO_RD then SKIP.
  - skip_req is driven as described above.
- **BITOP_SKIP_EN undefined:**
  - SBIC/SBIS are treated as ignored opcodes.
  - The SKIP state is not built and skip_req is tied to 0.

## Structure
- Shared package bitop_pkg holds:
  - the opcode match constants (C_SBI, C_CBI, C_BST, C_BLD, C_BSET, C_BCLR, C_SBIC, C_SBIS), taken from the common opcode definitions;
  - the state enumeration;
  - the I/O-address extraction width constant.
- One sub-module, bitop_class: a combinational opcode classifier that maps ir to one-hot class signals {io_rmw, io_skip, wb_rf, wb_tf, wb_sreg}. It is used on the accept path and, on ir_q, for strobe decode.
- The FSM and the holding registers stay in bit_op_seq.

## Test plan
- SBI 0x9A2B (A=5, b=3) with io_rdata=0x00 and bit unit attached: io_re at io_addr 0x05 in cycle 1, io_we with io_wdata=0x08 in cycle 2, stall high in cycles 1–2 only.
- CBI 0x9813 (A=2, b=3), io_rdata=0xFF, io_wait high for 2 cycles in each phase: io_we carries 0xF7 at addr 0x02 and is held for 3 cycles; ir_ready returns 7 cycles after accept.
- BLD 0xF8A5 (Rd=10, b=5), rf_rdata=0x00, T=1: single cycle with rf_we=1, rf_waddr=10, rf_wdata=0x20; no other strobes.
- BSET 0x9478 (s=7) with sreg=0x01, then BST 0xFA60 (Rd=6, b=0) back-to-back: sreg_wdata=0x81 in cycle 1; accept in cycle 2; tf_we in cycle 3.
- rst asserted in the io_we cycle of SBI: no io_we in the following cycle; state returns to IDLE; ir_ready=1, ir_q=0, io_rdata_q=0.
- BITOP_SKIP_EN defined, SBIS 0x9B29 (A=5, b=1) with io_rdata=0x02: skip_req=1 in cycle 2. With io_rdata=0x00, skip_req stays 0. With the macro undefined, the block stays in IDLE and no io_re is issued.

Source files
------------

// File: rtl/bitop_pkg.sv
// Shared opcode match constants, FSM state type and field widths for bit_op_seq.
// Defining BITOP_SKIP_EN adds the SKIP state used by SBIC/SBIS.
package bitop_pkg;

    localparam int C_IOA_W = 5;

    // Each opcode is a match value compared under the mask of its encoding group
    localparam logic [15:0] M_IOBIT = 16'hFF00;
    localparam logic [15:0] M_TFBIT = 16'hFE08;
    localparam logic [15:0] M_SRBIT = 16'hFF8F;

    localparam logic [15:0] C_CBI  = 16'h9800;
    localparam logic [15:0] C_SBIC = 16'h9900;
    localparam logic [15:0] C_SBI  = 16'h9A00;
    localparam logic [15:0] C_SBIS = 16'h9B00;
    localparam logic [15:0] C_BLD  = 16'hF800;
    localparam logic [15:0] C_BST  = 16'hFA00;
    localparam logic [15:0] C_BSET = 16'h9408;
    localparam logic [15:0] C_BCLR = 16'h9488;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_IO_RD = 3'd1,
        S_IO_WR = 3'd2,
`ifdef BITOP_SKIP_EN
        S_WB    = 3'd3,
        S_SKIP  = 3'd4
`else
        S_WB    = 3'd3
`endif
    } state_t;

    function automatic logic op_match(input logic [15:0] ir,
                                      input logic [15:0] match,
                                      input logic [15:0] mask);
        return (ir & mask) == match;
    endfunction

endpackage

// File: rtl/bitop_class.sv
// Combinational classifier mapping an instruction word to one-hot sequencing classes.
// SBIC/SBIS are only recognised when BITOP_SKIP_EN is defined.
module bitop_class
    import bitop_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic        o_io_rmw,
    output logic        o_io_skip,
    output logic        o_wb_rf,
    output logic        o_wb_tf,
    output logic        o_wb_sreg
);

    assign o_io_rmw  = op_match(i_ir, C_SBI, M_IOBIT) || op_match(i_ir, C_CBI, M_IOBIT);

`ifdef BITOP_SKIP_EN
    assign o_io_skip = op_match(i_ir, C_SBIC, M_IOBIT) || op_match(i_ir, C_SBIS, M_IOBIT);
`else
    assign o_io_skip = 1'b0;
`endif

    assign o_wb_rf   = op_match(i_ir, C_BLD, M_TFBIT);
    assign o_wb_tf   = op_match(i_ir, C_BST, M_TFBIT);
    assign o_wb_sreg = op_match(i_ir, C_BSET, M_SRBIT) || op_match(i_ir, C_BCLR, M_SRBIT);

endmodule

// File: rtl/bit_op_seq.sv
// Sequencer for SBI/CBI/BST/BLD/BSET/BCLR: latches the bit unit's operands and issues its write strobes.
// Define BITOP_SKIP_EN to also sequence SBIC/SBIS and drive skip_req.
module bit_op_seq
    import bitop_pkg::*;
#(
    parameter int IO_AW = 6
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ir_valid,
    input  logic [15:0]      ir,
    output logic             ir_ready,
    output logic             stall,
    output logic [15:0]      ir_q,
    output logic [7:0]       io_rdata_q,
    input  logic [7:0]       bsc_ro,
    input  logic             bst_tf,
    output logic [IO_AW-1:0] io_addr,
    output logic             io_re,
    output logic             io_we,
    output logic [7:0]       io_wdata,
    input  logic [7:0]       io_rdata,
    input  logic             io_wait,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [7:0]       rf_wdata,
    output logic             sreg_we,
    output logic [7:0]       sreg_wdata,
    output logic             tf_we,
    output logic             tf_wdata,
    output logic             skip_req
);

    state_t      r_state;
    logic [15:0] r_ir_q;
    logic [7:0]  r_io_rdata_q;

    logic w_accept;
    logic w_in_io_rmw, w_in_io_skip, w_in_wb_rf, w_in_wb_tf, w_in_wb_sreg;
    logic w_q_io_rmw, w_q_io_skip, w_q_wb_rf, w_q_wb_tf, w_q_wb_sreg;
    logic w_in_wb;

    bitop_class u_class_in (
        .i_ir      (ir),
        .o_io_rmw  (w_in_io_rmw),
        .o_io_skip (w_in_io_skip),
        .o_wb_rf   (w_in_wb_rf),
        .o_wb_tf   (w_in_wb_tf),
        .o_wb_sreg (w_in_wb_sreg)
    );

    bitop_class u_class_q (
        .i_ir      (r_ir_q),
        .o_io_rmw  (w_q_io_rmw),
        .o_io_skip (w_q_io_skip),
        .o_wb_rf   (w_q_wb_rf),
        .o_wb_tf   (w_q_wb_tf),
        .o_wb_sreg (w_q_wb_sreg)
    );

    assign w_accept = ir_valid && ir_ready;
    assign w_in_wb  = w_in_wb_rf || w_in_wb_tf || w_in_wb_sreg;

    // Unrecognised opcodes are latched but leave the FSM in IDLE, so ir_ready never drops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ir_q       <= 16'h0000;
            r_io_rdata_q <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ir_q <= ir;
                        if (w_in_io_rmw || w_in_io_skip) begin
                            r_state <= S_IO_RD;
                        end else if (w_in_wb) begin
                            r_state <= S_WB;
                        end
                    end
                end
                S_IO_RD: begin
                    if (!io_wait) begin
                        r_io_rdata_q <= io_rdata;
`ifdef BITOP_SKIP_EN
                        r_state      <= w_q_io_rmw ? S_IO_WR : S_SKIP;
`else
                        r_state      <= S_IO_WR;
`endif
                    end
                end
                S_IO_WR: begin
                    if (!io_wait) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WB:    r_state <= S_IDLE;
`ifdef BITOP_SKIP_EN
                S_SKIP:  r_state <= S_IDLE;
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ir_ready   = (r_state == S_IDLE);
    assign stall      = !ir_ready;
    assign ir_q       = r_ir_q;
    assign io_rdata_q = r_io_rdata_q;

    // Address and write data come straight from held registers, so they stay put across wait states
    assign io_addr    = {{(IO_AW - C_IOA_W){1'b0}}, r_ir_q[7:3]};
    assign io_re      = (r_state == S_IO_RD) && (w_q_io_rmw || w_q_io_skip);
    assign io_we      = (r_state == S_IO_WR) && w_q_io_rmw;
    assign io_wdata   = io_we ? bsc_ro : 8'h00;

    assign rf_we      = (r_state == S_WB) && w_q_wb_rf;
    assign rf_waddr   = r_ir_q[8:4];
    assign rf_wdata   = rf_we ? bsc_ro : 8'h00;

    assign sreg_we    = (r_state == S_WB) && w_q_wb_sreg;
    assign sreg_wdata = sreg_we ? bsc_ro : 8'h00;

    assign tf_we      = (r_state == S_WB) && w_q_wb_tf;
    assign tf_wdata   = tf_we ? bst_tf : 1'b0;

`ifdef BITOP_SKIP_EN
    // ir_q[9] selects SBIS (skip if set) versus SBIC (skip if clear)
    assign skip_req   = (r_state == S_SKIP) && (r_io_rdata_q[r_ir_q[2:0]] == r_ir_q[9]);
`else
    assign skip_req   = 1'b0;
`endif

endmodule
